// File: rtl/seq_mantissa_multiplier.sv
// Sequential shift-add mantissa multiplier: one partial product per clock,
// fixed WIDTH-cycle latency, unnormalised 2*WIDTH-bit product.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_mantissa_multiplier #(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] acc_hi_r;
  logic [WIDTH-1:0] acc_lo_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH-1:0] chain_s;
  logic [WIDTH:0]   sum_s;
  logic             last_step_s;

  // Partial product is the multiplicand when the multiplier bit under test is set
  assign addend_s = acc_lo_r[0] ? mcand_r : {WIDTH{1'b0}};

  half_adder u_ha (
    .a     (acc_hi_r[0]),
    .b     (addend_s[0]),
    .sum   (sum_s[0]),
    .carry (chain_s[0])
  );

  for (genvar i = 1; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (acc_hi_r[i]),
      .b    (addend_s[i]),
      .cin  (chain_s[i-1]),
      .sum  (sum_s[i]),
      .cout (chain_s[i])
    );
  end

  // carry_r is accumulator bit 2*WIDTH; it is always zero after a shift, so this stays exact
  assign sum_s[WIDTH] = carry_r ^ chain_s[WIDTH-1];

  // Next-state decode
  always_comb begin
    state_nx_s  = state_r;
    last_step_s = (cnt_r == CW'(WIDTH-1));
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = RUN;
        else       state_nx_s = IDLE;
      end
      RUN: begin
        if (last_step_s) state_nx_s = DONE;
        else             state_nx_s = RUN;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_nx_s != IDLE);
      done    <= (state_nx_s == DONE);
    end
  end

  // Operand capture, shift-add steps and product load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r  <= {WIDTH{1'b0}};
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      product  <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r  <= a;
            acc_lo_r <= b;
            acc_hi_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
          end
        end
        RUN: begin
          {carry_r, acc_hi_r, acc_lo_r} <= {1'b0, sum_s, acc_lo_r[WIDTH-1:1]};
          cnt_r <= cnt_r + CW'(1);
          if (last_step_s) product <= {sum_s, acc_lo_r[WIDTH-1:1]};
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mantissa_multiplier.sv
// Scoreboard bench: a latency/acceptance model queues a*b at each accepted
// start; a negedge monitor pops on done and checks busy, done and product.

module tb_seq_mantissa_multiplier;
  localparam int W = 24;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int             total = 0;
  int             bad = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_p;
  int             rem;
  int             accepts;
  int             cyc = 0;
  int             prev_done;
  bit             streaming = 1'b0;

  seq_mantissa_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an idle block accepts start and stays busy for W+1 cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem = 0;
      exp_q.delete();
      last_p = '0;
    end else begin
      cyc++;
      if (rem > 0) rem--;
      else if (start) begin
        rem = W + 1;
        accepts++;
        exp_q.push_back((2*W)'(a) * (2*W)'(b));
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 64'(busy), 64'(rem > 0));
      chk("done", 64'(done), 64'(rem == 1));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          last_p = exp_q.pop_front();
          chk("product", 64'(product), 64'(last_p));
        end
        if (streaming && prev_done >= 0) chk("done_spacing", 64'(cyc - prev_done), 64'd26);
        prev_done = cyc;
      end else begin
        chk("product_hold", 64'(product), 64'(last_p));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W + 2) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    accepts = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", 64'(product), 64'd0);
    rst = 1'b0;
    tick();

    op(24'h800000, 24'h800000);
    chk("half_by_half", 64'(product), 64'h400000000000);
    op(24'hFFFFFF, 24'hFFFFFF);
    chk("max_by_max", 64'(product), 64'hFFFFFE000001);
    op(24'hC00000, 24'h000000);
    chk("b_zero", 64'(product), 64'd0);
    op(24'h000000, 24'hABCDEF);
    chk("a_zero", 64'(product), 64'd0);

    // Restart attempt at step 5 with operands churning every cycle
    a = 24'h123456; b = 24'h654321; start = 1'b1;
    tick();
    for (int i = 1; i <= 30; i++) begin
      a = W'($urandom); b = W'($urandom);
      start = (i == 5);
      tick();
    end
    start = 1'b0;
    chk("ignore_restart", 64'(product), 64'(48'h123456 * 48'h654321));

    // Asynchronous abort mid-run
    a = 24'hABCDEF; b = 24'h777777; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_product", 64'(product), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    op(24'h000003, 24'h000005);
    chk("after_abort", 64'(product), 64'd15);

    // Back-to-back stream with start held high
    begin
      int target;
      int guard;
      target = accepts + 1000;
      guard = 0;
      prev_done = -1;
      streaming = 1'b1;
      start = 1'b1;
      while (accepts < target && guard < 40000) begin
        a = W'($urandom); b = W'($urandom);
        tick();
        guard++;
      end
      start = 1'b0;
      chk("stream_accepts", 64'(accepts), 64'(target));
      repeat (W + 3) tick();
      streaming = 1'b0;
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
